reg_scoreboard: RTL
===================

# reg_scoreboard

Producer-side hazard tracker for the 5-stage RISC-V pipeline, located in the ID stage. It records every register write issued into ID/EX, together with the number of cycles until that result can be forwarded. It stalls ID when a source operand cannot yet be forwarded (read-after-write) or when a write would overtake an older, slower write to the same register (write-after-write). It also rolls back the entry of an instruction squashed in ID/EX by a taken branch.

## Interface
Parameters:
- LOAD_LAT, 1, stall cycles owed to an immediately-following consumer of a load result
- MUL_LAT, 3, stall cycles owed for a multiply result (pipelined multiplier); must satisfy MUL_LAT ≥ LOAD_LAT ≥ 1
- CW, $clog2(MUL_LAT+1), width of each countdown

Ports:
- clk  in  1  clock; the block uses one clock only
- rst  in  1  reset, synchronous and active-high
- id_valid  in  1  valid instruction in ID
- id_rs1, id_rs2  in  5  source register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads that source
- id_rd  in  5  destination register index
- id_regwrite  in  1  instruction writes id_rd
- id_lat_sel  in  2  latency class: 00 ALU (latency 0), 01 load (LOAD_LAT), 10 mul (MUL_LAT), 11 treated as 00
- flush  in  1  taken branch; kills IF/ID and ID/EX this cycle
- stall  out  1  hold PC and IF/ID, inject a bubble into ID/EX (combinational)
- issue  out  1  id_valid & !stall & !flush (combinational)
- busy  out  32  busy[i] = (cnt[i] != 0), registered state

## Operation
- State: cnt[1..31], each CW bits wide; cnt[0] is constant 0. Shadow register: sh_valid, sh_rd[4:0], sh_cnt[CW-1:0].
- lat_new is derived from id_lat_sel.
- RAW hazard when (id_use_rs1 & id_rs1≠0 & cnt[id_rs1]≠0) | (id_use_rs2 & id_rs2≠0 & cnt[id_rs2]≠0).
- WAW hazard when id_regwrite & id_rd≠0 & cnt[id_rd] > lat_new.
- stall = id_valid & !flush & (RAW | WAW).
- On every clock edge:
  - Each nonzero cnt decrements by 1, saturating at 0.
  - When issue & id_regwrite & id_rd≠0: cnt[id_rd] is loaded with lat_new, overriding the decrement. The shadow is loaded with sh_valid=1, sh_rd=id_rd, and sh_cnt = saturating (cnt[id_rd] − 1), i.e. the value the entry would otherwise have taken.
  - Any other edge clears sh_valid.
- flush:
  - Suppresses issue, so ID is never recorded that cycle.
  - If sh_valid, the squashed ID/EX instruction is rolled back: cnt[sh_rd] <= saturating (sh_cnt − 1). The rollback overrides the normal decrement for that register.
  - sh_valid clears.
  - If flush is asserted with sh_valid=0, only the normal decrement occurs.
- Writes to x0 are never recorded; an x0 source never stalls.
- ALU producers load cnt=0, so they never stall consumers (the forwarding path covers them) and never create a busy entry.
- Simultaneous RAW and WAW: a single stall; resolution proceeds naturally as the counts drain.

## Timing
- Reset: all cnt=0, sh_valid=0, busy=0. stall and issue follow their equations (both 0 while id_valid=0). Reset applied mid-operation discards all entries on the next edge.
- A load issued at edge N sets cnt=LOAD_LAT. A dependent instruction in ID stalls for exactly LOAD_LAT cycles and issues on edge N+LOAD_LAT+1.
- A mul dependent stalls for exactly MUL_LAT cycles.
- busy updates one edge after issue or rollback.
- stall has no latency: it is combinational from the current state and the ID inputs.

## Test plan
- Load-use: lw x5 issued; next cycle add x6,x5,x1 in ID -> stall=1 for exactly 1 cycle; busy[5]=1 for 1 cycle, then 0; add issues on the following edge.
- Mul chain: mul x7 (MUL_LAT=3) followed by sub x8,x7,x7 -> stall=1 for 3 consecutive cycles, then issue=1.
- WAW: mul x9 then addi x9 back-to-back -> addi stalls 3 cycles (cnt 3>0, 2>0, 1>0) and issues when cnt[9]=0; an addi x9 with a load in flight to x9 stalls 1 cycle.
- x0 and unused sources: lw x0 then add x1,x0,x0 -> no stall, busy=0; lw x5 then lui x5-style instruction with id_use_rs1=0 reading x5 as rs1 -> no RAW stall.
- Flush rollback: lw x4 issued at edge N; flush at cycle N+1 -> busy[4]=0 after edge N+1, and a following consumer of x4 does not stall. Also mul x4 (edge N), lw x4 (edge N+3, cnt 0 by then), flush -> restored cnt=0.
- Reset mid-stall: mul x3, consumer stalling; rst=1 for one edge -> busy=0 and stall=0 on the next cycle.

Source files
------------

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - ID-stage register scoreboard: RAW/WAW stall generation and flush rollback
// Tracks cycles until each pending register result becomes forwardable.
module reg_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CW       = $clog2(MUL_LAT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic [1:0]  id_lat_sel,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy
);

  logic [CW-1:0] cnt_q [1:31];
  logic [CW-1:0] cnt_view [32];

  logic          sh_valid;
  logic [4:0]    sh_rd;
  logic [CW-1:0] sh_cnt;

  logic [CW-1:0] lat_new;
  logic          raw_rs1;
  logic          raw_rs2;
  logic          raw_hazard;
  logic          waw_hazard;
  logic          record;
  logic          rollback;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // x0 reads as a permanently idle entry so index 0 needs no special casing below.
  always_comb begin
    cnt_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_view[i] = cnt_q[i];
    end
  end

  always_comb begin
    lat_new = '0;
    case (id_lat_sel)
      2'b01:   lat_new = CW'(LOAD_LAT);
      2'b10:   lat_new = CW'(MUL_LAT);
      default: lat_new = '0;
    endcase
  end

  always_comb begin
    raw_rs1    = id_use_rs1 && (id_rs1 != 5'd0) && (cnt_view[id_rs1] != '0);
    raw_rs2    = id_use_rs2 && (id_rs2 != 5'd0) && (cnt_view[id_rs2] != '0);
    raw_hazard = raw_rs1 || raw_rs2;
    waw_hazard = id_regwrite && (id_rd != 5'd0) && (cnt_view[id_rd] > lat_new);
    stall      = id_valid && !flush && (raw_hazard || waw_hazard);
    issue      = id_valid && !stall && !flush;
    record     = issue && id_regwrite && (id_rd != 5'd0);
    rollback   = flush && sh_valid;
  end

  always_comb begin
    busy[0] = 1'b0;
    for (int i = 1; i < 32; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  // Record and rollback never coincide: flush suppresses issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      sh_valid <= 1'b0;
      sh_rd    <= 5'd0;
      sh_cnt   <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (record && (id_rd == 5'(i))) begin
          cnt_q[i] <= lat_new;
        end else if (rollback && (sh_rd == 5'(i))) begin
          cnt_q[i] <= sat_dec(sh_cnt);
        end else begin
          cnt_q[i] <= sat_dec(cnt_q[i]);
        end
      end
      if (record) begin
        sh_valid <= 1'b1;
        sh_rd    <= id_rd;
        sh_cnt   <= sat_dec(cnt_view[id_rd]);
      end else begin
        sh_valid <= 1'b0;
      end
    end
  end

endmodule
